hazard_detection_unit: RTL
==========================

// Module: hazard_detection_unit
// PURPOSE
//  Stall/flush controller, the counterpart of the forwarding unit: it handles the hazards that forwarding cannot cover.
//  Sits beside the ID stage of the 5-stage RV32I pipeline.
//  Detects load-use and ID-resolved branch/jalr data dependencies, then inserts bubbles.
//  Also freezes the whole pipe on cache misses and squashes wrong-path fetches after a taken branch or jump.
// PARAMETERS
//  REG_ADDR_W   5   register index width
//  LD_BR_STALL  2   stall cycles for a branch/jalr whose operand is produced by a load in EX
//  PERF_W       32  width of performance counters (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk            in   1   core clock
//  rst_n          in   1   asynchronous active-low reset
//  IF_ID_rs1      in   5   rs1 of the instruction in ID
//  IF_ID_rs2      in   5   rs2 of the instruction in ID
//  uses_rs2       in   1   ID instruction reads rs2 (R/S/B type)
//  branch, jalr   in   1   ID instruction is a branch / jalr (both resolve in ID)
//  ctrl_taken     in   1   ID branch taken, or jal/jalr (redirect PC)
//  ID_EX_rd       in   5   dest of the instruction in EX
//  ID_EX_memread  in   1   EX instruction is a load
//  ID_EX_regwrite in   1   EX instruction writes rd
//  EX_MEM_rd      in   5   dest of the instruction in MEM
//  EX_MEM_memread in   1   MEM instruction is a load
//  icache_stall   in   1   I-cache miss in progress
//  dcache_stall   in   1   D-cache miss in progress
//  pc_write       out  1   PC register enable
//  IF_ID_write    out  1   IF/ID register enable
//  IF_ID_flush    out  1   load a NOP into IF/ID
//  ID_EX_bubble   out  1   load a NOP (all control bits 0) into ID/EX
//  pipe_write     out  1   ID/EX, EX/MEM, MEM/WB enable
// BEHAVIOUR
//  Reset: state=RUN, dep_cnt=0, flush_pend=0. While rst_n=0, every enable output is 0 and flush/bubble are 0.
//  Match rules: rd==0 never matches. rs2 compares only when uses_rs2=1.
//  Dependency need N (evaluated in RUN):
//   - ID_EX_memread, rd matches any source                      -> N=1 (non-branch) or N=LD_BR_STALL (branch/jalr)
//   - branch/jalr, ID_EX_regwrite & !memread, rd match          -> N=1
//   - branch/jalr, EX_MEM_memread, EX_MEM_rd match              -> N=1
//   - otherwise                                                 -> N=0
//  States:
//   - RUN:
//     - N>0: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, pipe_write=1.
//     - If N>1: go to DEP with dep_cnt=N-1.
//     - N=0: all enables 1. ctrl_taken=1 sets IF_ID_flush=1 for that cycle.
//   - DEP: same outputs as a RUN stall cycle. dep_cnt decrements; at 1 -> RUN.
//     Hazard inputs are ignored in DEP, so the bubble count is exact.
//   - FRZ (entered from any state when icache_stall|dcache_stall):
//     - all enables 0, bubble 0, flush 0.
//     - The state it was entered from and dep_cnt are saved and held.
//     - On release it returns to the saved state the next cycle, and N is recomputed there.
//  Stall priority: cache stall > dependency stall > flush. Cache stall takes effect combinationally in the same cycle.
//  A cycle with a cache stall never writes a bubble.
//  Flush while frozen: ctrl_taken seen with a stall asserted sets flush_pend.
//   - The flush is issued in the first non-stalled RUN cycle, then flush_pend clears.
//   - Flush is never issued while a dependency stall holds ID, because the branch is not yet resolved.
//  Flush and a fresh stall in the same cycle: the stall wins and ctrl_taken is re-evaluated later.
//  Async reset mid-stall: immediate return to RUN, counters cleared, pending flush dropped.
// CONFIGURATION
//  `HAZARD_PERF_CNT_EN defined:
//   - adds outputs stall_cycles[PERF_W] and flush_count[PERF_W].
//   - stall_cycles counts cycles with ID_EX_bubble=1. flush_count counts IF_ID_flush pulses.
//   - Both saturate at all-ones and are cleared by rst_n.
//  Macro undefined: the ports and counters do not exist. Base behaviour is identical.
// STRUCTURE
//  hazard_pkg: state encoding (RUN, DEP, FRZ), REG_ADDR_W, NOP-instruction constant.
//  Sub-module hazard_match: purely combinational rd/rs comparison producing N.
//  This module holds the FSM, dep_cnt, flush_pend and the optional counters.
// TESTING
//  1. lw x5 in EX, add x6,x5,x7 in ID -> one cycle pc_write=0, IF_ID_write=0, ID_EX_bubble=1, then all enables 1.
//  2. lw x5 in EX, beq x5,x0 in ID -> 2 consecutive bubble cycles (RUN then DEP, dep_cnt 1), no flush until the beq resolves.
//  3. addi x5 in EX, jalr x1,0(x5) in ID -> 1 bubble. Next cycle, ctrl_taken=1 -> IF_ID_flush=1 for exactly 1 cycle.
//  4. dcache_stall for 3 cycles during DEP -> enables 0, no bubbles. After release, exactly 1 remaining bubble, then RUN.
//  5. ctrl_taken=1 together with icache_stall=1 for 2 cycles -> no flush while stalled, one IF_ID_flush on the first free cycle.
//  6. rst_n=0 pulsed mid-DEP -> outputs 0 immediately. After release: RUN, no bubble, pending flush gone.
//     With the macro defined, both counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard detection unit.
//   REG_ADDR_W : register index width
//   hz_state_t : controller state encoding (RUN, DEP, FRZ)
//   NOP_INSTR  : canonical RV32I NOP (addi x0,x0,0) loaded on flush/bubble
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_DEP = 2'd1,
        ST_FRZ = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side (drives ID/EX/MEM hazard info and cache stalls, receives enables)
//   slave  : hazard unit side
interface hazard_detection_unit_if;

    logic [hazard_pkg::REG_ADDR_W-1:0] IF_ID_rs1;
    logic [hazard_pkg::REG_ADDR_W-1:0] IF_ID_rs2;
    logic                              uses_rs2;
    logic                              branch;
    logic                              jalr;
    logic                              ctrl_taken;
    logic [hazard_pkg::REG_ADDR_W-1:0] ID_EX_rd;
    logic                              ID_EX_memread;
    logic                              ID_EX_regwrite;
    logic [hazard_pkg::REG_ADDR_W-1:0] EX_MEM_rd;
    logic                              EX_MEM_memread;
    logic                              icache_stall;
    logic                              dcache_stall;
    logic                              pc_write;
    logic                              IF_ID_write;
    logic                              IF_ID_flush;
    logic                              ID_EX_bubble;
    logic                              pipe_write;

    modport master (
        output IF_ID_rs1, IF_ID_rs2, uses_rs2, branch, jalr, ctrl_taken,
               ID_EX_rd, ID_EX_memread, ID_EX_regwrite,
               EX_MEM_rd, EX_MEM_memread, icache_stall, dcache_stall,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_write
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, uses_rs2, branch, jalr, ctrl_taken,
               ID_EX_rd, ID_EX_memread, ID_EX_regwrite,
               EX_MEM_rd, EX_MEM_memread, icache_stall, dcache_stall,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_write
    );

endinterface

// File: rtl/hazard_match.sv
// Combinational rd/rs comparison producing the dependency stall need.
//   rs1, rs2, uses_rs2     : sources of the ID instruction
//   branch, jalr           : ID instruction resolves in ID
//   ex_rd/memread/regwrite : producer in EX
//   mem_rd/memread         : producer in MEM
//   need_c                 : number of bubbles required (0 = none)
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned LD_BR_STALL = 2,
    parameter int unsigned CNT_W       = 2
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs2,
    input  logic                  branch,
    input  logic                  jalr,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memread,
    input  logic                  ex_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_memread,
    output logic [CNT_W-1:0]      need_c
);

    logic ex_match;
    logic mem_match;
    logic is_ctrl;

    // x0 is hard-wired zero and never carries a dependency
    assign ex_match  = (ex_rd != '0)  && ((ex_rd == rs1)  || (uses_rs2 && (ex_rd == rs2)));
    assign mem_match = (mem_rd != '0) && ((mem_rd == rs1) || (uses_rs2 && (mem_rd == rs2)));
    assign is_ctrl   = branch | jalr;

    // Load-use dominates; ID-resolved control needs every operand ready in ID
    always_comb begin
        need_c = '0;
        if (ex_memread && ex_match) begin
            need_c = is_ctrl ? CNT_W'(LD_BR_STALL) : CNT_W'(1);
        end else if (is_ctrl && ex_regwrite && ex_match) begin
            need_c = CNT_W'(1);
        end else if (is_ctrl && mem_memread && mem_match) begin
            need_c = CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller beside the ID stage of the 5-stage RV32I pipeline.
// Inserts bubbles for load-use and ID-resolved branch/jalr dependencies,
// freezes the pipe on cache misses and squashes wrong-path fetches.
//   clk, rst_n : core clock, asynchronous active-low reset
//   hz         : hazard_detection_unit_if.slave (hazard inputs, pipeline enables)
// Optional: `HAZARD_PERF_CNT_EN adds saturating counters stall_cycles and
// flush_count (PERF_W bits each).
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int unsigned LD_BR_STALL = 2
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W      = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard_detection_unit_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]       stall_cycles,
    output logic [PERF_W-1:0]       flush_count
`endif
);

    localparam int unsigned CNT_W = $clog2(LD_BR_STALL + 1);

    hz_state_t        state_q, state_d;
    hz_state_t        saved_q, saved_d;
    logic [CNT_W-1:0] dep_cnt_q, dep_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] need_c;
    logic             cache_stall_c;

    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c, pipe_write_c;
    logic bubble_o, flush_o;

    hazard_match #(
        .LD_BR_STALL (LD_BR_STALL),
        .CNT_W       (CNT_W)
    ) u_match (
        .rs1         (hz.IF_ID_rs1),
        .rs2         (hz.IF_ID_rs2),
        .uses_rs2    (hz.uses_rs2),
        .branch      (hz.branch),
        .jalr        (hz.jalr),
        .ex_rd       (hz.ID_EX_rd),
        .ex_memread  (hz.ID_EX_memread),
        .ex_regwrite (hz.ID_EX_regwrite),
        .mem_rd      (hz.EX_MEM_rd),
        .mem_memread (hz.EX_MEM_memread),
        .need_c      (need_c)
    );

    assign cache_stall_c = hz.icache_stall | hz.dcache_stall;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            saved_q      <= ST_RUN;
            dep_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            dep_cnt_q    <= dep_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Next state and enables; a cache stall overrides everything in the same cycle
    always_comb begin
        state_d         = state_q;
        saved_d         = saved_q;
        dep_cnt_d       = dep_cnt_q;
        flush_pend_d    = flush_pend_q;
        pc_write_c      = 1'b0;
        if_id_write_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        pipe_write_c    = 1'b0;

        if (cache_stall_c) begin
            if (state_q != ST_FRZ) begin
                saved_d = state_q;
            end
            state_d = ST_FRZ;
            // Redirect seen under a freeze is remembered and issued later
            if (hz.ctrl_taken) begin
                flush_pend_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (need_c != '0) begin
                        id_ex_bubble_c = 1'b1;
                        pipe_write_c   = 1'b1;
                        if (need_c > CNT_W'(1)) begin
                            state_d   = ST_DEP;
                            dep_cnt_d = need_c - CNT_W'(1);
                        end
                    end else begin
                        pc_write_c    = 1'b1;
                        if_id_write_c = 1'b1;
                        pipe_write_c  = 1'b1;
                        if_id_flush_c = hz.ctrl_taken | flush_pend_q;
                        flush_pend_d  = 1'b0;
                    end
                end
                // Hazard inputs ignored here so the bubble count stays exact
                ST_DEP: begin
                    id_ex_bubble_c = 1'b1;
                    pipe_write_c   = 1'b1;
                    dep_cnt_d      = dep_cnt_q - CNT_W'(1);
                    if (dep_cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                // Release cycle stays frozen; the saved state resumes next cycle
                ST_FRZ: begin
                    state_d = saved_q;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Everything is held low while reset is asserted
    assign bubble_o = rst_n & id_ex_bubble_c;
    assign flush_o  = rst_n & if_id_flush_c;

    assign hz.pc_write     = rst_n & pc_write_c;
    assign hz.IF_ID_write  = rst_n & if_id_write_c;
    assign hz.IF_ID_flush  = flush_o;
    assign hz.ID_EX_bubble = bubble_o;
    assign hz.pipe_write   = rst_n & pipe_write_c;

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (bubble_o && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (flush_o && (flush_count != '1)) begin
                flush_count <= flush_count + PERF_W'(1);
            end
        end
    end
`endif

endmodule
